// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: single-cycle ALU plus 32-step restoring HI/LO divider
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  alu_sel,
    input  logic [7:0]  alu_op,
    input  logic [31:0] src_data1,
    input  logic [31:0] src_data2,
    input  logic [4:0]  wr_addr,
    input  logic        wr_en,
    input  logic        flush,
    output logic [31:0] ex_wr_data,
    output logic [4:0]  ex_wr_addr,
    output logic        ex_wr_en,
    output logic        ex_hilo_wr_en,
    output logic [31:0] ex_hi,
    output logic [31:0] ex_lo,
    output logic        stall_req
);

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b110;

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [4:0] LAST_STEP = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ZERO, ON, DONE} div_state_t;

    div_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        neg_quo_q, neg_rem_q;

    logic        is_div_class, is_div_op, div_signed;
    logic [31:0] abs_a, abs_b;
    logic [32:0] trial;
    logic [33:0] diff;
    logic [31:0] div_hi, div_lo;
    logic [31:0] alu_result;
    logic        overflow;
    logic        stall, hilo_wr;

    assign is_div_class = (alu_sel == SEL_DIV);
    assign is_div_op    = is_div_class && (alu_op == OP_DIV || alu_op == OP_DIVU);
    assign div_signed   = (alu_op == OP_DIV);
    assign abs_a        = (div_signed && src_data1[31]) ? -src_data1 : src_data1;
    assign abs_b        = (div_signed && src_data2[31]) ? -src_data2 : src_data2;

    // Trial subtraction on the left-shifted remainder; diff[33] set means borrow.
    assign trial  = {rem_q, quo_q[31]};
    assign diff   = {1'b0, trial} - {2'b00, dvs_q};
    assign div_lo = neg_quo_q ? -quo_q : quo_q;
    assign div_hi = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        unique case (alu_sel)
            SEL_LOGIC: begin
                case (alu_op)
                    OP_OR:   alu_result = src_data1 | src_data2;
                    OP_AND:  alu_result = src_data1 & src_data2;
                    OP_XOR:  alu_result = src_data1 ^ src_data2;
                    OP_NOR:  alu_result = ~(src_data1 | src_data2);
                    default: alu_result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (alu_op)
                    OP_SLL:  alu_result = src_data2 << src_data1[4:0];
                    OP_SRL:  alu_result = src_data2 >> src_data1[4:0];
                    OP_SRA:  alu_result = $signed(src_data2) >>> src_data1[4:0];
                    default: alu_result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (alu_op)
                    OP_ADD: begin
                        alu_result = src_data1 + src_data2;
                        overflow   = (src_data1[31] == src_data2[31]) &&
                                     (alu_result[31] != src_data1[31]);
                    end
                    OP_ADDU: alu_result = src_data1 + src_data2;
                    OP_SUB: begin
                        alu_result = src_data1 - src_data2;
                        overflow   = (src_data1[31] != src_data2[31]) &&
                                     (alu_result[31] != src_data1[31]);
                    end
                    OP_SUBU: alu_result = src_data1 - src_data2;
                    OP_SLT:  alu_result = {31'b0, $signed(src_data1) < $signed(src_data2)};
                    OP_SLTU: alu_result = {31'b0, src_data1 < src_data2};
                    default: alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        hilo_wr   = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div_op) begin
                        stall     = 1'b1;
                        state_nxt = (src_data2 == '0) ? ZERO : ON;
                    end
                end
                ZERO: begin
                    stall     = 1'b1;
                    state_nxt = DONE;
                end
                ON: begin
                    stall = 1'b1;
                    if (cnt == LAST_STEP) state_nxt = DONE;
                end
                DONE: begin
                    hilo_wr   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (is_div_op) begin
                            cnt   <= '0;
                            rem_q <= '0;
                            if (src_data2 == '0) begin
                                quo_q     <= '0;
                                dvs_q     <= '0;
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                            end else begin
                                quo_q     <= abs_a;
                                dvs_q     <= abs_b;
                                neg_quo_q <= div_signed && (src_data1[31] ^ src_data2[31]);
                                neg_rem_q <= div_signed && src_data1[31];
                            end
                        end
                    end
                    ON: begin
                        if (!diff[33]) begin
                            rem_q <= diff[31:0];
                            quo_q <= {quo_q[30:0], 1'b1};
                        end else begin
                            rem_q <= trial[31:0];
                            quo_q <= {quo_q[30:0], 1'b0};
                        end
                        if (cnt != LAST_STEP) cnt <= cnt + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Everything is forced to zero while reset is held, including the pure passthroughs.
    always_comb begin
        ex_wr_data    = '0;
        ex_wr_addr    = '0;
        ex_wr_en      = 1'b0;
        ex_hilo_wr_en = 1'b0;
        ex_hi         = '0;
        ex_lo         = '0;
        stall_req     = 1'b0;
        if (reset) begin
            ex_wr_addr    = wr_addr;
            ex_wr_data    = alu_result;
            ex_wr_en      = wr_en & ~overflow & ~flush & ~is_div_class;
            stall_req     = stall;
            ex_hilo_wr_en = hilo_wr;
            if (hilo_wr) begin
                ex_hi = div_hi;
                ex_lo = div_lo;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_op;
    logic [31:0] src_data1, src_data2;
    logic [4:0]  wr_addr;
    logic        wr_en, flush;
    logic [31:0] ex_wr_data, ex_hi, ex_lo;
    logic [4:0]  ex_wr_addr;
    logic        ex_wr_en, ex_hilo_wr_en, stall_req;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage dut (
        .clk(clk), .reset(reset), .alu_sel(alu_sel), .alu_op(alu_op),
        .src_data1(src_data1), .src_data2(src_data2), .wr_addr(wr_addr),
        .wr_en(wr_en), .flush(flush), .ex_wr_data(ex_wr_data),
        .ex_wr_addr(ex_wr_addr), .ex_wr_en(ex_wr_en), .ex_hilo_wr_en(ex_hilo_wr_en),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] op_sel [13] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [7:0] op_code[13] = '{8'h25, 8'h24, 8'h26, 8'h27, 8'h7C, 8'h02, 8'h03,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h2A, 8'h2B};
    logic [31:0] edge_vals[6] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                                  32'h1, 32'h0000_001F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: {write_enable, data} from plain 64-bit arithmetic.
    function automatic logic [32:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic we);
        longint sa, sb, wide;
        logic [31:0] r;
        logic ok;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 32'h0;
        ok = 1'b1;
        wide = 0;
        if (sel == 3'b001) begin
            if (op == 8'h25) r = a | b;
            else if (op == 8'h24) r = a & b;
            else if (op == 8'h26) r = a ^ b;
            else if (op == 8'h27) r = ~(a | b);
        end else if (sel == 3'b010) begin
            if (op == 8'h7C) r = b << a[4:0];
            else if (op == 8'h02) r = b >> a[4:0];
            else if (op == 8'h03) begin
                wide = sb >>> a[4:0];
                r = wide[31:0];
            end
        end else if (sel == 3'b100) begin
            if (op == 8'h20 || op == 8'h21) begin
                wide = sa + sb;
                r = wide[31:0];
                if (op == 8'h20 && (wide > 64'sd2147483647 || wide < -64'sd2147483648)) ok = 1'b0;
            end else if (op == 8'h22 || op == 8'h23) begin
                wide = sa - sb;
                r = wide[31:0];
                if (op == 8'h22 && (wide > 64'sd2147483647 || wide < -64'sd2147483648)) ok = 1'b0;
            end else if (op == 8'h2A) r = (sa < sb) ? 32'd1 : 32'd0;
            else if (op == 8'h2B) r = (a < b) ? 32'd1 : 32'd0;
        end else if (sel == 3'b110) begin
            ok = 1'b0;
        end
        return {we & ok, r};
    endfunction

    // Reference: {hi, lo}; zero divisor yields zero.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint x, y, q, r;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_alu(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic we,
                          input logic [31:0] exp_data, input logic exp_en);
        logic [4:0] addr;
        addr = 5'($urandom_range(0, 31));
        @(posedge clk);
        #1;
        alu_sel = sel; alu_op = op; src_data1 = a; src_data2 = b;
        wr_addr = addr; wr_en = we; flush = 1'b0;
        #1;
        check("alu_data", ex_wr_data, exp_data);
        check("alu_wr_en", {31'b0, ex_wr_en}, {31'b0, exp_en});
        check("alu_addr", {27'b0, ex_wr_addr}, {27'b0, addr});
        check("alu_side", {29'b0, stall_req, ex_hilo_wr_en, |{ex_hi, ex_lo}}, 32'h0);
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int stalls;
        @(posedge clk);
        #1;
        alu_sel = 3'b110; alu_op = sgn ? 8'h1A : 8'h1B;
        src_data1 = a; src_data2 = b; wr_en = 1'b1; flush = 1'b0;
        wr_addr = 5'd3;
        #1;
        stalls = 0;
        while (stall_req && stalls < 100) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        check("div_stalls", 32'(stalls), (b == 32'h0) ? 32'd2 : 32'd33);
        check("div_hilo_we", {31'b0, ex_hilo_wr_en}, 32'd1);
        check("div_hi", ex_hi, exp_hi);
        check("div_lo", ex_lo, exp_lo);
        check("div_gpr", {ex_wr_data[30:0], ex_wr_en}, 32'h0);
        @(posedge clk);
        #1;
        alu_sel = 3'b000; alu_op = 8'h00;
        #1;
        check("div_pulse_end", {30'b0, ex_hilo_wr_en, stall_req}, 32'h0);
    endtask

    initial begin
        logic [63:0] hl;
        logic [32:0] exp;
        logic [31:0] a, b;
        int k;

        reset = 1'b0; flush = 1'b0; alu_sel = 3'b001; alu_op = 8'h25;
        src_data1 = 32'h1234_5678; src_data2 = 32'h0F0F_0000; wr_addr = 5'd7; wr_en = 1'b1;
        #12;
        check("reset_data", ex_wr_data, 32'h0);
        check("reset_ctl", {26'b0, ex_wr_addr, ex_wr_en}, 32'h0);
        check("reset_div", {30'b0, stall_req, ex_hilo_wr_en}, 32'h0);
        reset = 1'b1;

        do_alu(3'b001, 8'h25, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, 32'h0F0F_00FF, 1'b1);
        do_alu(3'b100, 8'h20, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0);
        do_alu(3'b100, 8'h21, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1);
        do_alu(3'b100, 8'h22, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b0);
        do_alu(3'b010, 8'h03, 32'h0000_0004, 32'hF000_0000, 1'b1, 32'hFF00_0000, 1'b1);
        do_alu(3'b100, 8'h2A, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h1, 1'b1);
        do_alu(3'b100, 8'h2B, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, 1'b1);
        do_alu(3'b111, 8'h25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);

        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
        do_div(32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0000_000F, 32'h0FFF_FFFF);
        do_div(32'd1234, 32'h0, 1'b1, 32'h0, 32'h0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Reset asserted asynchronously while the divider is at step 10.
        @(posedge clk);
        #1;
        alu_sel = 3'b110; alu_op = 8'h1A; src_data1 = 32'd1000; src_data2 = 32'd3; wr_en = 1'b1;
        repeat (11) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("rst_mid_div", {29'b0, stall_req, ex_hilo_wr_en, ex_wr_en}, 32'h0);
        check("rst_mid_hilo", ex_hi | ex_lo | ex_wr_data, 32'h0);
        alu_sel = 3'b001; alu_op = 8'h25; src_data1 = 32'h0F0F_0000; src_data2 = 32'h0000_00FF;
        wr_addr = 5'd9;
        #1;
        check("rst_gate_or", ex_wr_data, 32'h0);
        check("rst_gate_addr", {26'b0, ex_wr_addr, ex_wr_en}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("post_rst_or", ex_wr_data, 32'h0F0F_00FF);
        check("post_rst_en", {31'b0, ex_wr_en}, 32'd1);
        k = 0;
        repeat (3) begin
            @(posedge clk);
            #2;
            if (ex_hilo_wr_en || stall_req) k++;
        end
        check("post_rst_idle", 32'(k), 32'd0);

        // Flush in the 13th ON cycle aborts the division without a HI/LO write.
        @(posedge clk);
        #1;
        alu_sel = 3'b110; alu_op = 8'h1B; src_data1 = 32'd100; src_data2 = 32'd7; wr_en = 1'b1;
        repeat (13) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall", {30'b0, stall_req, ex_hilo_wr_en}, 32'h0);
        check("flush_wr_en", {31'b0, ex_wr_en}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0; alu_sel = 3'b000; alu_op = 8'h00;
        k = 0;
        repeat (40) begin
            #1;
            if (ex_hilo_wr_en || stall_req) k++;
            @(posedge clk);
            #1;
        end
        check("flush_no_pulse", 32'(k), 32'd0);
        do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 12);
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
            if ($urandom_range(0, 15) == 0) begin
                exp = ref_alu(3'b011, op_code[k], a, b, 1'b1);
                do_alu(3'b011, op_code[k], a, b, 1'b1, exp[31:0], exp[32]);
            end else begin
                exp = ref_alu(op_sel[k], op_code[k], a, b, i[0] | i[1]);
                do_alu(op_sel[k], op_code[k], a, b, i[0] | i[1], exp[31:0], exp[32]);
            end
        end

        for (int i = 0; i < 12; i++) begin
            a = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom();
            b = ($urandom_range(0, 5) == 0) ? 32'h0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom();
            if (i == 5) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            hl = ref_div(a, b, i[0]);
            do_div(a, b, i[0], hl[63:32], hl[31:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage; sits directly downstream of the ID/EX pipeline register and consumes its registered outputs (alu_sel, alu_op, two source operands, write address, write enable).
- Single-cycle logic, shift and arithmetic ops are computed combinationally.
- DIV/DIVU run on a 32-iteration sequential restoring divider that holds the pipeline via stall_req until the HI/LO result is ready.
- Outputs feed the EX/MEM register.

Parameters:
DIV_CYCLES, 32, divider iterations (one quotient bit per cycle; fixed to operand width)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
alu_sel  input  3  result class: 001 logic, 010 shift, 100 arithmetic, 110 divide, others -> result 0
alu_op  input  8  OR 25h, AND 24h, XOR 26h, NOR 27h, SLL 7Ch, SRL 02h, SRA 03h, ADD 20h, ADDU 21h, SUB 22h, SUBU 23h, SLT 2Ah, SLTU 2Bh, DIV 1Ah, DIVU 1Bh
src_data1  input  32  operand A (shift amount in [4:0] for shifts; dividend)
src_data2  input  32  operand B (shifted value; divisor)
wr_addr  input  5  destination register
wr_en  input  1  destination write enable
flush  input  1  abort in-flight division, force outputs to bubble
ex_wr_data  output  32  GPR result
ex_wr_addr  output  5  passthrough of wr_addr
ex_wr_en  output  1  qualified GPR write enable
ex_hilo_wr_en  output  1  HI/LO write strobe
ex_hi  output  32  remainder
ex_lo  output  32  quotient
stall_req  output  1  EX-stage stall request to the pipeline controller

Behaviour:
- Reset (reset=0, async): state IDLE, counter 0, divider registers 0. All outputs 0 while reset is low (combinational outputs are gated by reset).
- Logic, shift and arithmetic ops, zero latency:
  - Shift: SLL/SRL/SRA shift src_data2 by src_data1[4:0]; SRA sign-fills.
  - ADD/ADDU/SUB/SUBU: 32-bit wrap.
  - ADD/SUB signed overflow (operand signs equal for add or differ for sub, and result sign differs from A): ex_wr_en=0, ex_wr_data still the wrapped sum.
  - SLT: signed compare; SLTU: unsigned compare; result 0 or 1.
- ex_wr_en = wr_en & !overflow & !flush. Divide ops: ex_wr_en=0, ex_wr_data=0.
- Divider FSM (registered state IDLE, ZERO, ON, DONE):
  - IDLE: on a DIV/DIVU op with flush=0:
    - divisor==0 -> ZERO
    - otherwise -> ON, latching |A| and |B| (signed) or raw values (unsigned), sign flags and counter=0.
    - stall_req=1 in this cycle.
  - ZERO: stall_req=1, result {HI,LO}=0 -> DONE.
  - ON: stall_req=1, one restoring step per cycle (shift the remainder/quotient pair left by 1; subtract the divisor if no borrow; set the quotient bit). When counter==31 -> DONE, else counter++.
  - DONE:
    - stall_req=0, ex_hilo_wr_en=1.
    - Signed results: quotient negated if signs differ; remainder takes the dividend's sign.
    - Next -> IDLE. The ID/EX register advances on this edge, so no re-trigger.
  - Total: 33 stall cycles for a normal divide, 2 for divide-by-zero; result visible in the 34th (resp. 3rd) cycle.
- flush=1 in any state: next state IDLE, stall_req=0, ex_hilo_wr_en=0, ex_wr_en=0 in that cycle.
- Async reset mid-division: immediate IDLE, no HI/LO write.
- Non-divide ops: ex_hilo_wr_en=0, ex_hi=ex_lo=0.
- Back-to-back divides: the second begins in the cycle after DONE (IDLE sees the new op).

Test Plan:
- Reset low mid-ON (counter=10) -> all outputs 0 immediately. After release, ORI-class OR 0x0F0F0000|0x000000FF -> ex_wr_data=0x0F0F00FF, ex_wr_en=1.
- ADD 0x7FFFFFFF+0x00000001, wr_en=1 -> ex_wr_data=0x80000000, ex_wr_en=0. ADDU with the same operands -> ex_wr_en=1.
- SRA src_data1=4, src_data2=0xF0000000 -> 0xFF000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
- DIV 7 / -2 -> stall_req high 33 cycles, then ex_lo=0xFFFFFFFD, ex_hi=0x00000001, ex_hilo_wr_en=1 for one cycle. DIVU 0xFFFFFFFF/0x10 -> lo=0x0FFFFFFF, hi=0xF.
- DIV x/0 -> stall_req high exactly 2 cycles, then hi=lo=0, ex_hilo_wr_en=1.
- flush asserted at ON cycle 12 -> stall_req=0 the same cycle, state IDLE, no ex_hilo_wr_en pulse. A following DIVU 9/3 completes normally with lo=3, hi=0.
